// File: rtl/ext_rx_buffer.sv
// Elastic store between the external RX read-data port and the TCDM write side:
// buffers DEPTH 64-bit beats and drains each as two 32-bit words, low half first.
module ext_rx_buffer #(
    parameter int DEPTH     = 4,
    parameter int CNT_WIDTH = $clog2(DEPTH) + 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    input  logic [63:0]          rx_data_dat_i,
    input  logic                 rx_data_req_i,
    output logic                 rx_data_gnt_o,
    output logic [31:0]          out_dat_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [CNT_WIDTH-1:0] count_o,
    output logic                 empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [63:0]          mem_q [DEPTH];
    logic [CNT_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic                 half_q, half_d;
    logic                 full, empty, push, pop;
    logic [63:0]          rd_beat;

    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);

    // Grant depends only on stored state, clear and reset -- never on the request.
    assign rx_data_gnt_o = rst_ni && !full && !clear_i;
    assign push          = rx_data_req_i && rx_data_gnt_o;
    assign out_valid_o   = !empty;
    assign pop           = out_valid_o && out_ready_i && !clear_i;

    assign rd_beat   = mem_q[rd_ptr_q[AW-1:0]];
    assign out_dat_o = empty ? 32'h0 : (half_q ? rd_beat[63:32] : rd_beat[31:0]);
    assign count_o   = wr_ptr_q - rd_ptr_q;
    assign empty_o   = empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        half_d   = half_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            half_d   = 1'b0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop) begin
                half_d = !half_q;
                if (half_q) rd_ptr_d = rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            half_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            half_q   <= half_d;
        end
    end

    // Storage array is intentionally left unreset.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= rx_data_dat_i;
    end

endmodule
